// File: rtl/pong_input_ctrl.sv
// Button conditioning and game pacing for the pong logic: two-flop synchronisers,
// per-button debounce FSMs with press pulses, an up/down conflict mask and a periodic tick.

module pong_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // press is raised only on the PRESS_WAIT exit, so a bounce back from RELEASE_WAIT stays silent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                RELEASED: begin
                    cnt <= '0;
                    if (sync2) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    cnt <= '0;
                    if (!sync2) begin
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign lvl = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

module pong_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int TICK_DIV        = 1083333
) (
    input  logic clk,
    input  logic rst,
    input  logic up_raw,
    input  logic down_raw,
    output logic up,
    output logic down,
    output logic up_press,
    output logic down_press,
    output logic timing_tick
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          lvl_up;
    logic          lvl_down;
    logic [TW-1:0] tick_cnt;

    pong_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
        .clk  (clk),
        .rst  (rst),
        .raw  (up_raw),
        .lvl  (lvl_up),
        .press(up_press)
    );

    pong_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down (
        .clk  (clk),
        .rst  (rst),
        .raw  (down_raw),
        .lvl  (lvl_down),
        .press(down_press)
    );

    // Holding both buttons means "no movement"; the mask is combinational so it adds no latency
    assign up   = lvl_up & ~lvl_down;
    assign down = lvl_down & ~lvl_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt    <= '0;
            timing_tick <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt    <= '0;
            timing_tick <= 1'b1;
        end else begin
            tick_cnt    <= tick_cnt + TW'(1);
            timing_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Self-checking bench for pong_input_ctrl: directed scenarios with literal expectations
// plus randomised bouncing buttons checked every cycle against a sample-history model.

module tb_pong_input_ctrl;

    localparam int DEB   = 4;
    localparam int TDIV  = 10;
    localparam int TDIV2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_raw = 1'b0;
    logic down_raw = 1'b0;
    logic up, down, up_press, down_press, timing_tick;
    logic up_b, down_b, up_press_b, down_press_b, tick_b;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pong_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst(rst), .up_raw(up_raw), .down_raw(down_raw),
        .up(up), .down(down), .up_press(up_press), .down_press(down_press),
        .timing_tick(timing_tick)
    );

    pong_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV2)) dut2 (
        .clk(clk), .rst(rst), .up_raw(up_raw), .down_raw(down_raw),
        .up(up_b), .down(down_b), .up_press(up_press_b), .down_press(down_press_b),
        .timing_tick(tick_b)
    );

    task automatic check_output(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level flips once the last DEB+1 synchronised samples all disagree with it;
    // the synchronised sample at an edge is the raw value taken two edges earlier.
    bit lvl_m[2];
    bit press_m[2];
    bit tick_m, tick2_m;
    int n_m;
    bit raw_q[2][$];
    bit in_q[2][$];

    initial begin
        bit r, s, all_diff;
        forever begin
            @(posedge clk);
            if (rst) begin
                n_m = 0;
                tick_m = 0;
                tick2_m = 0;
                for (int ch = 0; ch < 2; ch++) begin
                    raw_q[ch] = {1'b0, 1'b0};
                    in_q[ch] = {};
                    lvl_m[ch] = 0;
                    press_m[ch] = 0;
                end
            end else begin
                n_m++;
                for (int ch = 0; ch < 2; ch++) begin
                    r = (ch == 0) ? up_raw : down_raw;
                    s = raw_q[ch][0];
                    raw_q[ch].push_back(r);
                    void'(raw_q[ch].pop_front());
                    in_q[ch].push_back(s);
                    if (in_q[ch].size() > DEB + 1) void'(in_q[ch].pop_front());
                    press_m[ch] = 0;
                    if (in_q[ch].size() == DEB + 1) begin
                        all_diff = 1;
                        for (int k = 0; k < in_q[ch].size(); k++)
                            if (in_q[ch][k] == lvl_m[ch]) all_diff = 0;
                        if (all_diff) begin
                            lvl_m[ch] = !lvl_m[ch];
                            press_m[ch] = lvl_m[ch];
                        end
                    end
                end
                tick_m  = (n_m % TDIV) == 0;
                tick2_m = (n_m % TDIV2) == 0;
            end
            #1;
            check_output("model_up", up, lvl_m[0] && !lvl_m[1]);
            check_output("model_down", down, lvl_m[1] && !lvl_m[0]);
            check_output("model_up_press", up_press, press_m[0]);
            check_output("model_down_press", down_press, press_m[1]);
            check_output("model_tick", timing_tick, tick_m);
            check_output("model_tick_div2", tick_b, tick2_m);
        end
    end

    // Bounded wait: 0 = up, 1 = down, 2 = down_press
    task automatic wait_for(input int which, input string name);
        int c;
        logic v;
        c = 0;
        v = 1'b0;
        while (c < 40) begin
            @(posedge clk);
            #2;
            c++;
            case (which)
                0:       v = up;
                1:       v = down;
                default: v = down_press;
            endcase
            if (v) break;
        end
        check_output(name, v, 1'b1);
    endtask

    task automatic apply_stimulus_random(input int cycles);
        int rem_u, rem_d;
        rem_u = 0;
        rem_d = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rem_u == 0) begin
                up_raw = 1'($urandom_range(0, 1));
                rem_u = $urandom_range(1, 9);
            end
            if (rem_d == 0) begin
                down_raw = 1'($urandom_range(0, 1));
                rem_d = $urandom_range(1, 9);
            end
            rem_u--;
            rem_d--;
        end
    endtask

    bit pat[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_output("rst_up", up, 1'b0);
        check_output("rst_down", down, 1'b0);
        check_output("rst_up_press", up_press, 1'b0);
        check_output("rst_down_press", down_press, 1'b0);
        check_output("rst_tick", timing_tick, 1'b0);

        // clean press straight out of reset: pins press latency and first tick
        @(negedge clk);
        rst = 0;
        up_raw = 1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #2;
            check_output($sformatf("clean_up_e%0d", e), up, e >= 7);
            check_output($sformatf("clean_press_e%0d", e), up_press, e == 7);
            check_output($sformatf("clean_tick_e%0d", e), timing_tick, e == 10);
            check_output($sformatf("clean_down_e%0d", e), down, 1'b0);
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        up_raw = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #2;
            check_output($sformatf("release_up_e%0d", e), up, e < 7);
        end

        // bounce rejection
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            up_raw = pat[i];
            @(posedge clk);
            #2;
            check_output($sformatf("bounce_up_%0d", i), up, 1'b0);
            check_output($sformatf("bounce_press_%0d", i), up_press, 1'b0);
        end
        @(negedge clk);
        up_raw = 1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #2;
            check_output($sformatf("bounce_hold_up_e%0d", e), up, e >= 7);
            check_output($sformatf("bounce_hold_press_e%0d", e), up_press, e == 7);
        end

        // release bounce while pressed
        @(negedge clk);
        up_raw = 0;
        @(negedge clk);
        @(negedge clk);
        up_raw = 1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #2;
            check_output($sformatf("relbounce_up_e%0d", e), up, 1'b1);
            check_output($sformatf("relbounce_press_e%0d", e), up_press, 1'b0);
        end
        @(negedge clk);
        up_raw = 0;
        repeat (12) @(posedge clk);

        // conflict
        @(negedge clk);
        up_raw = 1;
        wait_for(0, "conflict_up_rise");
        repeat (3) @(posedge clk);
        @(negedge clk);
        down_raw = 1;
        wait_for(2, "conflict_down_press");
        check_output("conflict_up_masked", up, 1'b0);
        check_output("conflict_down_masked", down, 1'b0);
        @(negedge clk);
        up_raw = 0;
        wait_for(1, "conflict_down_after_up_release");
        @(negedge clk);
        down_raw = 0;
        repeat (12) @(posedge clk);

        apply_stimulus_random(1500);

        // async reset while pressed
        @(negedge clk);
        up_raw = 1;
        down_raw = 0;
        repeat (12) @(posedge clk);
        #2;
        check_output("pre_async_up", up, 1'b1);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check_output("async_rst_up", up, 1'b0);
        check_output("async_rst_up_press", up_press, 1'b0);
        check_output("async_rst_tick", timing_tick, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // reset again during PRESS_WAIT with count 2, then require a full fresh debounce
        repeat (5) @(posedge clk);
        #3;
        rst = 1;
        #1;
        check_output("pw_rst_up", up, 1'b0);
        check_output("pw_rst_down", down, 1'b0);
        check_output("pw_rst_tick", timing_tick, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #2;
            check_output($sformatf("fresh_up_e%0d", e), up, e >= 7);
            check_output($sformatf("fresh_press_e%0d", e), up_press, e == 7);
            check_output($sformatf("fresh_tick_e%0d", e), timing_tick, e == 10);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/pong_input_ctrl.md
# pong_input_ctrl

Input conditioning and game-timing front end for the pong logic. Synchronises and debounces the raw `up`/`down` buttons and produces clean levels and one-cycle press pulses. Also generates the periodic `timing_tick` strobe that paces the ball, pad and score controllers. Outputs connect directly to the `up`, `down` and `timing_tick` inputs of the game logic top.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 650000: number of consecutive stable synchronised samples needed to accept a level change. This is 10 ms at 65 MHz. Legal range is ≥ 2.
- `TICK_DIV`, default 1083333: clock cycles per `timing_tick`. This is about 60 Hz at 65 MHz. Legal range is ≥ 2.

Ports:
- `clk`, input, 1 bit: system clock (65 MHz pixel clock). The block uses one clock.
- `rst`, input, 1 bit: reset. Asynchronous, active-high.
- `up_raw`, input, 1 bit: raw up button. Asynchronous to `clk` and may bounce.
- `down_raw`, input, 1 bit: raw down button. Asynchronous to `clk` and may bounce.
- `up`, output, 1 bit: debounced up level, after the conflict rule is applied.
- `down`, output, 1 bit: debounced down level, after the conflict rule is applied.
- `up_press`, output, 1 bit: one-cycle pulse when a debounced up press is accepted.
- `down_press`, output, 1 bit: one-cycle pulse when a debounced down press is accepted.
- `timing_tick`, output, 1 bit: one-cycle strobe, asserted once every `TICK_DIV` cycles.

## Operation
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser: `sync1` then `sync2`. The FSM sees only `sync2`.
- **Per-channel FSM.** Up and down have independent, identical FSMs. Each FSM has a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - **RELEASED:** the counter is held at 0. `sync2`=1 moves to PRESS_WAIT with the counter at 0.
  - **PRESS_WAIT:**
    - `sync2`=0: return to RELEASED and clear the counter.
    - `sync2`=1 and counter = `DEBOUNCE_CYCLES`-1: move to PRESSED and clear the counter.
    - Otherwise: counter +1.
  - **PRESSED:** `sync2`=0 moves to RELEASE_WAIT with the counter at 0.
  - **RELEASE_WAIT:**
    - `sync2`=1: return to PRESSED and clear the counter.
    - `sync2`=0 and counter = `DEBOUNCE_CYCLES`-1: move to RELEASED and clear the counter.
    - Otherwise: counter +1.
  - **Illegal state encoding:** go to RELEASED.
- **Debounced level.** `lvl_x` = 1 in PRESSED and RELEASE_WAIT. It is derived only from the state register, so it is glitch-free.
- **Conflict rule:**
  - `up` = `lvl_up` & ~`lvl_down`.
  - `down` = `lvl_down` & ~`lvl_up`.
  - If both channels are debounced high, both outputs are 0.
- **Press pulses.**
  - `x_press` is a registered flag, set for exactly the first cycle the FSM is in PRESSED after leaving PRESS_WAIT.
  - A return RELEASE_WAIT→PRESSED does not pulse.
  - Pulses are not masked by the conflict rule.
- **Tick generator.**
  - Free-running counter of width `$clog2(TICK_DIV)`.
  - At count = `TICK_DIV`-1 the counter wraps to 0, and `timing_tick` is registered high for the following cycle only.
  - The tick runs regardless of button activity.
- **Reset.**
  - Async assert clears everything immediately: sync flops, FSMs to RELEASED, all counters to 0, all outputs to 0.
  - Reset mid-debounce discards the partial count.
  - After deassert the block restarts from the RELEASED / count-0 condition.

## Timing
- Reset values: `up`=`down`=`up_press`=`down_press`=`timing_tick`=0.
- **Press latency.** Let edge 1 be the first rising edge that samples `up_raw`=1. With the raw input held stable:
  - edge 3: the FSM enters PRESS_WAIT.
  - edge `DEBOUNCE_CYCLES`+3: the FSM enters PRESSED.
  - `up` and `up_press` are high in the cycle after that edge.
- **Release latency:** symmetric, also `DEBOUNCE_CYCLES`+3 edges.
- **Rejected glitches.** Any raw pulse or dropout seen by `sync2` for fewer than `DEBOUNCE_CYCLES` cycles produces no output change and no pulse.
- **Conflict rule timing.** The rule adds zero latency. `up` drops in the same cycle that `lvl_down` rises.
- **Tick period:**
  - The first `timing_tick` is high in the cycle after edge `TICK_DIV` following reset deassert.
  - Subsequent ticks occur exactly `TICK_DIV` cycles apart.
  - The tick is never high for two consecutive cycles.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `TICK_DIV`=10 unless stated otherwise.
- **Clean press/release.**
  - Stimulus: `up_raw` 0→1 held for 20 cycles, then 0.
  - Response: `up` rises after edge 7 and falls 7 edges after the release is sampled. `up_press` is high for exactly 1 cycle. `down` and `down_press` stay 0.
- **Bounce rejection.**
  - Stimulus: toggle `up_raw` 1,0,1,0 with 2-cycle pulses, then hold 1.
  - Response: no `up` or `up_press` until 7 edges after the final rising sample. Exactly one pulse.
- **Release bounce.**
  - Stimulus: while pressed, drop `up_raw` for 2 cycles, then restore.
  - Response: `up` stays 1 throughout and no second `up_press` occurs.
- **Conflict.**
  - Stimulus: press up; 3 cycles after `up` asserts, press down and hold both.
  - Response: `down_press` pulses once. From the cycle `lvl_down` rises, `up`=0 and `down`=0. Releasing up (+7 edges) leaves `down`=1.
- **Tick.**
  - Stimulus: run 100 cycles.
  - Response: 10 ticks, each 1 cycle wide and 10 cycles apart, with the first after edge 10.
  - Stimulus: repeat with `TICK_DIV`=2.
  - Response: tick on alternate cycles.
- **Async reset mid-operation.**
  - Stimulus: assert `rst` between clock edges while in PRESS_WAIT with the counter at 2.
  - Response: all outputs 0 immediately, without waiting for a clock edge. After deassert with `up_raw` still 1, `up` rises after a full fresh `DEBOUNCE_CYCLES`+3 edges, and the tick phase restarts from 0.
